// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encodings shared by the UART receiver and
// transmitter.
//   DATA_BITS  - data bits per character (8N1 framing)
//   OVERSAMPLE - clock ticks per bit period
//   MID_SAMPLE - tick within the start bit where the line is evaluated
//   uart_state_t - frame FSM states
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/receive_rx_bit_counter.sv
// rx_bit_counter: oversample tick counter and data-bit index for the UART
// receiver.
//   clk, rst_n        - clock and asynchronous active-low reset
//   cnt_clr, cnt_en   - clear (wins) / advance the tick counter
//   idx_clr, idx_inc  - clear (wins) / advance the bit index
//   idx               - current data-bit index
//   cnt_mid           - tick counter is at the mid-bit sample point
//   cnt_last          - tick counter is at its last tick (wraps next)
//   idx_last          - bit index points at the final data bit
module rx_bit_counter #(
    parameter int NUM_TICKS = 16,
    parameter int NUM_BITS  = 8,
    parameter int CNT_W     = $clog2(NUM_TICKS),
    parameter int IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    input  logic             cnt_en,
    input  logic             idx_clr,
    input  logic             idx_inc,
    output logic [IDX_W-1:0] idx,
    output logic             cnt_mid,
    output logic             cnt_last,
    output logic             idx_last
);
    import uart_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            // Explicit wrap keeps the period exact for non power-of-two rates.
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        if (idx_clr) begin
            idx_d = '0;
        end else if (idx_inc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign cnt_mid  = (cnt_q == CNT_MID);
    assign cnt_last = (cnt_q == CNT_LAST);
    assign idx_last = (idx_q == IDX_LAST);

endmodule

// File: rtl/receive.sv
// receive: oversampling 8N1 UART receiver.
//   clk9600x16   - clock at OVERSAMPLE x bit rate, rising edge only
//   rst          - asynchronous active-low reset
//   dataIn       - asynchronous serial line, idle high, LSB first
//   dataRead     - consumer acknowledge; clears dataValid/overrun/frameErr
//   dataOut      - last good character
//   charReceived - one-cycle pulse per good frame
//   dataValid    - high while dataOut is unread
//   frameErr     - sticky: a stop bit was sampled low
//   overrun      - sticky: a good frame landed while dataValid was high
//   state_dbg    - current frame FSM state
// Handshake: dataValid rises with each good frame and stays high until a
// cycle with dataRead=1; a frame completing on that same edge wins and
// leaves dataValid high.
module receive #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk9600x16,
    input  logic                 rst,
    input  logic                 dataIn,
    input  logic                 dataRead,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 charReceived,
    output logic                 dataValid,
    output logic                 frameErr,
    output logic                 overrun,
    output logic [1:0]           state_dbg
);
    import uart_pkg::*;

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 sync1_q, sync2_q;
    uart_state_t          state_q, state_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 char_q, char_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic             line;
    logic             cnt_clr, cnt_en, idx_clr, idx_inc;
    logic [IDX_W-1:0] idx;
    logic             cnt_mid, cnt_last, idx_last;
    logic             stop_good, stop_bad;

    assign line = sync2_q;

    rx_bit_counter #(
        .NUM_TICKS (OVERSAMPLE),
        .NUM_BITS  (DATA_BITS)
    ) u_cnt (
        .clk      (clk9600x16),
        .rst_n    (rst),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .idx_clr  (idx_clr),
        .idx_inc  (idx_inc),
        .idx      (idx),
        .cnt_mid  (cnt_mid),
        .cnt_last (cnt_last),
        .idx_last (idx_last)
    );

    // Frame FSM. armed_q remembers that the line was high on the previous
    // IDLE cycle, so a start needs a real 1->0 edge and a line still low
    // after a framing error cannot start a new frame.
    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b0;
        shift_d   = shift_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                idx_clr = 1'b1;
                armed_d = line;
                if (armed_q && !line) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (cnt_mid) begin
                    if (line) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_clr = 1'b1;
                        idx_clr = 1'b1;
                    end
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    shift_d[idx] = line;
                    idx_inc      = 1'b1;
                    if (idx_last) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    stop_good = line;
                    stop_bad  = !line;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags: a set event on the same edge beats dataRead.
    always_comb begin
        data_out_d = stop_good ? shift_q : data_out_q;
        char_d     = stop_good;
        valid_d    = stop_good | (valid_q & ~dataRead);
        ovr_d      = (stop_good & valid_q & ~dataRead) | (ovr_q & ~dataRead);
        ferr_d     = stop_bad | (ferr_q & ~stop_good & ~dataRead);
    end

    always_ff @(posedge clk9600x16 or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            shift_q    <= '0;
            data_out_q <= '0;
            char_q     <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= dataIn;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            armed_q    <= armed_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            char_q     <= char_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign dataOut      = data_out_q;
    assign charReceived = char_q;
    assign dataValid    = valid_q;
    assign frameErr     = ferr_q;
    assign overrun      = ovr_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_receive.sv
// tb_receive: directed self-checking bench for the UART receiver.
module tb_receive;

    localparam logic [1:0] ST_IDLE = 2'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       data_read;
    logic [7:0] data_out;
    logic       char_received;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic [1:0] state_dbg;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cr_count = 0;
    int         last_cr_cyc = 0;
    logic [7:0] cr_data = 8'h00;

    receive dut (
        .clk9600x16   (clk),
        .rst          (rst),
        .dataIn       (data_in),
        .dataRead     (data_read),
        .dataOut      (data_out),
        .charReceived (char_received),
        .dataValid    (data_valid),
        .frameErr     (frame_err),
        .overrun      (overrun),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every high-sampled cycle counts, so a stretched pulse
    // shows up as an extra count.
    always @(negedge clk) begin
        if (char_received === 1'b1) begin
            cr_count    = cr_count + 1;
            last_cr_cyc = cyc;
            cr_data     = data_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    // Drives one 8N1 frame, 16 clocks per bit. With auto_read set, dataRead
    // is raised for the cycle in which charReceived is seen high.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input bit auto_read, output int t0);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        @(negedge clk);
        t0 = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 16; k++) begin
                data_in   = bits[b];
                data_read = auto_read && (char_received === 1'b1);
                @(negedge clk);
            end
        end
        data_in   = 1'b1;
        data_read = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; data_in = 1'b1; data_read = 1'b0;
        #2 rst = 1'b0;
        idle_clocks(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected %h", data_out, 8'h00); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (char_received !== 1'b0) begin errors++; $display("FAIL reset_char: got %b expected 0", char_received); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        rst = 1'b1;
        idle_clocks(20);
    endtask

    task automatic test_good_frame();
        int c0, t0, lat;
        c0 = cr_count;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle_clocks(4);
        // Line falls at the synchronizer output two clocks after it is driven.
        lat = last_cr_cyc - (t0 + 2);
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected %h", data_out, 8'hA5); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_ferr: got %b expected 0", frame_err); end
        checks++; if (cr_count - c0 != 1) begin errors++; $display("FAIL good_pulse_cycles: got %0d expected 1", cr_count - c0); end
        checks++; if (cr_data !== 8'hA5) begin errors++; $display("FAIL good_data_at_pulse: got %h expected %h", cr_data, 8'hA5); end
        checks++; if (lat < 151 || lat > 153) begin errors++; $display("FAIL good_latency: got %0d expected 151..153", lat); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = cr_count;
        @(negedge clk);
        data_in = 1'b0;
        idle_clocks(4);
        data_in = 1'b1;
        idle_clocks(30);
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        checks++; if (cr_count - c0 != 0) begin errors++; $display("FAIL glitch_char: got %0d expected 0", cr_count - c0); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected %h", data_out, 8'hA5); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid: got %b expected 1", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
    endtask

    task automatic test_frame_error();
        int c0, t0;
        c0 = cr_count;
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        idle_clocks(4);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h expected %h", data_out, 8'hA5); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b expected 1", data_valid); end
        checks++; if (cr_count - c0 != 0) begin errors++; $display("FAIL ferr_char: got %0d expected 0", cr_count - c0); end
        // Low stop bit must not be mistaken for a new start edge.
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL ferr_rearm_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        idle_clocks(20);
    endtask

    task automatic test_overrun();
        int t0;
        pulse_read();
        idle_clocks(1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL read_valid: got %b expected 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL read_ferr: got %b expected 0", frame_err); end
        send_frame(8'h11, 1'b1, 1'b0, t0);
        idle_clocks(4);
        checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h expected %h", data_out, 8'h11); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
        send_frame(8'h22, 1'b1, 1'b0, t0);
        idle_clocks(4);
        checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL ovr_second_data: got %h expected %h", data_out, 8'h22); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_second_flag: got %b expected 1", overrun); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ovr_second_valid: got %b expected 1", data_valid); end
        pulse_read();
        idle_clocks(1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_read_valid: got %b expected 0", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_read_flag: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int c0, t0;
        @(negedge clk);
        data_in = 1'b0;
        idle_clocks(16);
        data_in = 1'b1;
        idle_clocks(64 + 4);
        rst = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data_out, 8'h00); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        checks++; if ({data_valid, char_received, frame_err, overrun} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_flags: got %b expected 0000", {data_valid, char_received, frame_err, overrun});
        end
        idle_clocks(5);
        rst = 1'b1;
        idle_clocks(20);
        c0 = cr_count;
        send_frame(8'h5A, 1'b1, 1'b0, t0);
        idle_clocks(4);
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL rstmid_new_data: got %h expected %h", data_out, 8'h5A); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b expected 1", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_new_ferr: got %b expected 0", frame_err); end
        checks++; if (cr_count - c0 != 1) begin errors++; $display("FAIL rstmid_new_char: got %0d expected 1", cr_count - c0); end
    endtask

    task automatic test_back_to_back();
        int c0, t0;
        pulse_read();
        idle_clocks(2);
        c0 = cr_count;
        send_frame(8'h00, 1'b1, 1'b1, t0);
        checks++; if (cr_count - c0 != 1) begin errors++; $display("FAIL b2b_first_char: got %0d expected 1", cr_count - c0); end
        checks++; if (cr_data !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", cr_data, 8'h00); end
        send_frame(8'hFF, 1'b1, 1'b1, t0);
        idle_clocks(4);
        checks++; if (cr_count - c0 != 2) begin errors++; $display("FAIL b2b_second_char: got %0d expected 2", cr_count - c0); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h expected %h", data_out, 8'hFF); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b expected 0", overrun); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", data_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
